// File: rtl/sc_point_pkg.sv
// sc_point_pkg: state encoding, shift codes and direction flag values shared by the point FSM and the register stage.
package sc_point_pkg;
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_SHL  = 3'd4,
    ST_SHR  = 3'd5
  } state_t;
  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/sc_button_edge.sv
// sc_button_edge: 2-FF synchronizer plus one-cycle falling-edge pulse for an active-low button.
module sc_button_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_fall
);
  logic r_meta, r_sync, r_last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_last <= 1'b1;
    end else begin
      r_meta <= i_btn_n;
      r_sync <= r_meta;
      r_last <= r_sync;
    end
  end
  assign o_fall = r_last & ~r_sync;
endmodule

// File: rtl/sc_statemachine_point.sv
// sc_statemachine_point: button-driven control FSM for the point register with Moore-decoded commands.
// Auto-shift period counter and upcount_out are built only when SC_STATEMACHINEPOINT_AUTOSHIFT_EN is defined.
module sc_statemachine_point
  import sc_point_pkg::*;
#(
  parameter int TICK_WIDTH = 20,
  parameter logic [TICK_WIDTH-1:0] TICK_MAX = 20'd999999
) (
  input  logic       SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic       SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic       SC_STATEMACHINEPOINT_start_InLow,
  input  logic       SC_STATEMACHINEPOINT_left_InLow,
  input  logic       SC_STATEMACHINEPOINT_right_InLow,
  input  logic       SC_STATEMACHINEPOINT_clear_InLow,
  output logic       SC_STATEMACHINEPOINT_clear_OutLow,
  output logic       SC_STATEMACHINEPOINT_load1_OutLow,
  output logic [1:0] SC_STATEMACHINEPOINT_shiftselection_Out,
  output logic       SC_STATEMACHINEPOINT_T0_InLow,
  output logic       SC_STATEMACHINEPOINT_upcount_out
);
  state_t r_state, w_next;
  logic w_clr, w_start, w_left, w_right, w_tick, w_dir;
  sc_button_edge u_clr (.clk(SC_STATEMACHINEPOINT_CLOCK_50), .rst(SC_STATEMACHINEPOINT_RESET_InHigh),
                        .i_btn_n(SC_STATEMACHINEPOINT_clear_InLow), .o_fall(w_clr));
  sc_button_edge u_start (.clk(SC_STATEMACHINEPOINT_CLOCK_50), .rst(SC_STATEMACHINEPOINT_RESET_InHigh),
                          .i_btn_n(SC_STATEMACHINEPOINT_start_InLow), .o_fall(w_start));
  sc_button_edge u_left (.clk(SC_STATEMACHINEPOINT_CLOCK_50), .rst(SC_STATEMACHINEPOINT_RESET_InHigh),
                         .i_btn_n(SC_STATEMACHINEPOINT_left_InLow), .o_fall(w_left));
  sc_button_edge u_right (.clk(SC_STATEMACHINEPOINT_CLOCK_50), .rst(SC_STATEMACHINEPOINT_RESET_InHigh),
                          .i_btn_n(SC_STATEMACHINEPOINT_right_InLow), .o_fall(w_right));
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) r_state <= ST_INIT;
    else r_state <= w_next;
  end
  // Clear overrides every state; within RUN buttons outrank the auto tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: w_next = ST_IDLE;
      ST_IDLE: w_next = w_start ? ST_LOAD : ST_IDLE;
      ST_LOAD: w_next = ST_RUN;
      ST_RUN:  w_next = w_left ? ST_SHL : w_right ? ST_SHR : !w_tick ? ST_RUN : w_dir ? ST_SHR : ST_SHL;
      ST_SHL, ST_SHR: w_next = ST_RUN;
      default: w_next = ST_INIT;
    endcase
    if (w_clr) w_next = ST_INIT;
  end
`ifdef SC_STATEMACHINEPOINT_AUTOSHIFT_EN
  logic [TICK_WIDTH-1:0] r_count;
  logic r_dir;
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      r_count <= '0;
      r_dir   <= DIR_LEFT;
    end else begin
      r_count <= (r_state == ST_RUN && w_next == ST_RUN) ? (r_count == TICK_MAX ? '0 : r_count + 1'b1) : '0;
      r_dir   <= (r_state == ST_LOAD || w_next == ST_SHL) ? DIR_LEFT : w_next == ST_SHR ? DIR_RIGHT : r_dir;
    end
  end
  assign w_tick = r_state == ST_RUN && r_count == TICK_MAX;
  assign w_dir  = r_dir;
  assign SC_STATEMACHINEPOINT_upcount_out = w_tick;
`else
  assign w_tick = 1'b0;
  assign w_dir  = DIR_LEFT;
  // Parameters stay referenced so both builds share one interface.
  assign SC_STATEMACHINEPOINT_upcount_out = 1'b0 & |TICK_MAX;
`endif
  assign SC_STATEMACHINEPOINT_clear_OutLow = r_state != ST_INIT;
  assign SC_STATEMACHINEPOINT_load1_OutLow = r_state != ST_LOAD;
  assign SC_STATEMACHINEPOINT_shiftselection_Out = r_state == ST_SHL ? SHIFT_LEFT : r_state == ST_SHR ? SHIFT_RIGHT : SHIFT_HOLD;
  assign SC_STATEMACHINEPOINT_T0_InLow = !(r_state == ST_INIT || r_state == ST_IDLE);
endmodule

// File: tb/tb_sc_statemachine_point.sv
// tb_sc_statemachine_point: directed bench with a cycle-level reference model of the point FSM (TICK_MAX=4).
module tb_sc_statemachine_point;
`ifdef SC_STATEMACHINEPOINT_AUTOSHIFT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 0, rst = 0, start_n = 1, left_n = 1, right_n = 1, clear_n = 1;
  logic o_clear, o_load, o_t0, o_up;
  logic [1:0] o_shift;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sc_statemachine_point #(.TICK_WIDTH(20), .TICK_MAX(20'd4)) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50(clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
    .SC_STATEMACHINEPOINT_start_InLow(start_n),
    .SC_STATEMACHINEPOINT_left_InLow(left_n),
    .SC_STATEMACHINEPOINT_right_InLow(right_n),
    .SC_STATEMACHINEPOINT_clear_InLow(clear_n),
    .SC_STATEMACHINEPOINT_clear_OutLow(o_clear),
    .SC_STATEMACHINEPOINT_load1_OutLow(o_load),
    .SC_STATEMACHINEPOINT_shiftselection_Out(o_shift),
    .SC_STATEMACHINEPOINT_T0_InLow(o_t0),
    .SC_STATEMACHINEPOINT_upcount_out(o_up)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Model modes: 0 clearing, 1 waiting for start, 2 loading, 3 running, 4 one shift cycle.
  // Each button history holds samples from the last three edges; an event is a 1->0 seen two edges late.
  int mode = 0, cnt = 0;
  bit dir = 0;
  logic [1:0] msh = 0;
  logic [2:0] h [4] = '{default: 3'b111};
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= 0;
      cnt <= 0;
      dir <= 0;
      msh <= 0;
      for (int i = 0; i < 4; i++) h[i] <= 3'b111;
    end else begin : model_step
      logic [3:0] ev;
      logic [3:0] smp;
      int nm;
      bit tick;
      smp = {right_n, left_n, start_n, clear_n};
      for (int i = 0; i < 4; i++) begin
        ev[i] = !h[i][1] && h[i][2];
        h[i] <= {h[i][1:0], smp[i]};
      end
      tick = AUTO && mode == 3 && cnt == 4;
      nm = mode == 0 ? 1 : mode == 1 ? (ev[1] ? 2 : 1) : mode == 2 ? 3 : mode == 4 ? 3 :
           (ev[2] || ev[3] || tick) ? 4 : 3;
      if (ev[0]) nm = 0;
      if (mode == 2) dir <= 0;
      if (mode == 3 && nm == 4) begin
        msh <= ev[2] ? 2'd1 : ev[3] ? 2'd2 : dir ? 2'd2 : 2'd1;
        dir <= ev[2] ? 1'b0 : ev[3] ? 1'b1 : dir;
      end
      cnt <= (mode == 3 && nm == 3) ? cnt + 1 : 0;
      mode <= nm;
    end
  end
  always @(negedge clk) begin
    chk("m_clear", o_clear, mode != 0);
    chk("m_load", o_load, mode != 2);
    chk("m_shift", o_shift, mode == 4 ? msh : 2'd0);
    chk("m_t0", o_t0, mode >= 2);
    chk("m_up", o_up, AUTO && mode == 3 && cnt == 4);
  end
`ifdef SC_STATEMACHINEPOINT_AUTOSHIFT_EN
  task automatic wait_up();
    int n = 0;
    while (o_up !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("wait_up", o_up, 1);
  endtask
`endif
  initial begin
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clear", o_clear, 0);
    chk("rst_load", o_load, 1);
    chk("rst_shift", o_shift, 0);
    chk("rst_t0", o_t0, 0);
    chk("rst_up", o_up, 0);
    rst = 0;
    #1 chk("rel_clear_low", o_clear, 0);
    step();
    chk("init_one_cycle", o_clear, 1);
    chk("idle_t0", o_t0, 0);
    repeat (2) step();
    start_n = 0;
    step(); chk("load_n", o_load, 1);
    step(); chk("load_n1", o_load, 1);
    step(); chk("load_pulse", o_load, 0); chk("load_t0", o_t0, 1);
    step(); chk("load_end", o_load, 1); chk("run_t0", o_t0, 1);
    repeat (6) step();
    start_n = 1;
`ifdef SC_STATEMACHINEPOINT_AUTOSHIFT_EN
    begin : auto_tests
      int n;
      wait_up();
      step(); chk("auto_shl", o_shift, 1); chk("auto_up_gone", o_up, 0);
      n = 0;
      do begin step(); n++; end while (o_up !== 1'b1 && n < 20);
      chk("auto_period", n, 6);
      right_n = 0;
      repeat (3) step(); chk("right_shift", o_shift, 2);
      right_n = 1;
      repeat (6) step(); chk("auto_right", o_shift, 2);
      wait_up();
      left_n = 0; right_n = 0;
      repeat (3) step(); chk("both_left", o_shift, 1);
      left_n = 1; right_n = 1;
      wait_up();
      repeat (4) step();
      right_n = 0;
      repeat (3) step(); chk("tick_collide", o_shift, 2);
      step(); chk("no_extra", o_shift, 0);
      right_n = 1;
      repeat (3) step(); chk("up_not_yet", o_up, 0);
      step(); chk("up_after5", o_up, 1);
      wait_up();
    end
`else
    repeat (20) begin
      step();
      chk("no_auto_shift", o_shift, 0);
      chk("no_up", o_up, 0);
    end
`endif
    clear_n = 0;
    repeat (3) step(); chk("clear_pulse", o_clear, 0);
    step(); chk("clear_idle", o_clear, 1); chk("clear_t0", o_t0, 0);
    clear_n = 1;
    start_n = 0;
    repeat (4) step();
    start_n = 1;
`ifdef SC_STATEMACHINEPOINT_AUTOSHIFT_EN
    wait_up();
`endif
    right_n = 0;
    repeat (3) step(); chk("shr_before_rst", o_shift, 2);
    #1 rst = 1;
    #1;
    chk("rst_async_shift", o_shift, 0);
    chk("rst_async_clear", o_clear, 0);
    chk("rst_async_load", o_load, 1);
    right_n = 1;
    repeat (2) step();
    rst = 0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
